// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer board block.
package countdown_timer_pkg;

    localparam int CLK_HZ_DEFAULT = 12_000_000;
    localparam int LED_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    // Debounce window in clock cycles, never less than one.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
        int unsigned cycles;
        cycles = (clk_hz / 1000) * ms;
        return (cycles == 0) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stability counter; clean follows noisy
// only after it has held a new level for the whole debounce window.
module button_debounce
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic clean
);

    localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int          CNT_W     = $clog2(DB_CYCLES + 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             clean_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= 2'b00;
            cnt_reg   <= '0;
            clean_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], noisy};
            if (sync_reg[1] == clean_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
                clean_reg <= sync_reg[1];
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign clean = clean_reg;

endmodule

// File: rtl/countdown_timer_button_press.sv
// One active-low button turned into a single-cycle press pulse: debounced
// level, then a registered rising-edge detect so a held button fires once.
module button_press
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_n,
    output logic press
);

    logic level;
    logic level_d_reg;
    logic press_reg;

    button_debounce #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .noisy (~noisy_n),
        .clean (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_reg <= 1'b0;
            press_reg   <= 1'b0;
        end else begin
            level_d_reg <= level;
            press_reg   <= level & ~level_d_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer on the 4 LEDs: button 0 sets a preset, button 1 starts,
// pauses and resumes; the LEDs blink at zero until any button is pressed.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = 20,
    parameter int BLINK_DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       pmod,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W      = $clog2(CLK_HZ);
    localparam int BLINK_HALF = CLK_HZ / BLINK_DIV;
    localparam int BLK_W      = $clog2(BLINK_HALF + 1);

    logic [1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            button_press #(
                .CLK_HZ      (CLK_HZ),
                .DEBOUNCE_MS (DEBOUNCE_MS)
            ) u_press (
                .clk     (clk),
                .rst_n   (rst_n),
                .noisy_n (pmod[gi]),
                .press   (press[gi])
            );
        end
    endgenerate

    state_t           state_reg;
    logic [LED_W-1:0] preset_reg;
    logic [LED_W-1:0] value_reg;
    logic [PRE_W-1:0] presc_reg;
    logic [BLK_W-1:0] blink_cnt_reg;
    logic             blink_reg;
    logic [LED_W-1:0] led_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             tick;

    assign tick = (presc_reg == PRE_W'(CLK_HZ - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            preset_reg    <= '0;
            value_reg     <= '0;
            presc_reg     <= '0;
            blink_cnt_reg <= '0;
            blink_reg     <= 1'b0;
            led_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (press[1]) begin
                        if (preset_reg != '0) begin
                            state_reg <= ST_RUN;
                            value_reg <= preset_reg;
                            presc_reg <= '0;
                            led_reg   <= preset_reg;
                            busy_reg  <= 1'b1;
                        end
                    end else if (press[0]) begin
                        preset_reg <= preset_reg + 1'b1;
                        led_reg    <= preset_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    // A pause that lands on the tick keeps the second pending.
                    if (press[1]) begin
                        state_reg <= ST_PAUSE;
                        if (!tick) begin
                            presc_reg <= presc_reg + 1'b1;
                        end
                    end else if (tick) begin
                        presc_reg <= '0;
                        if (value_reg == LED_W'(1)) begin
                            state_reg     <= ST_EXPIRED;
                            value_reg     <= '0;
                            led_reg       <= '0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            blink_cnt_reg <= BLK_W'(BLINK_HALF - 1);
                            blink_reg     <= 1'b0;
                        end else begin
                            value_reg <= value_reg - 1'b1;
                            led_reg   <= value_reg - 1'b1;
                        end
                    end else begin
                        presc_reg <= presc_reg + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (press[0]) begin
                        state_reg <= ST_IDLE;
                        value_reg <= '0;
                        led_reg   <= preset_reg;
                        busy_reg  <= 1'b0;
                    end else if (press[1]) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    if (|press) begin
                        state_reg <= ST_IDLE;
                        led_reg   <= preset_reg;
                    end else if (blink_cnt_reg == BLK_W'(BLINK_HALF - 1)) begin
                        blink_cnt_reg <= '0;
                        blink_reg     <= ~blink_reg;
                        led_reg       <= {LED_W{~blink_reg}};
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign led  = led_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-plus-random bench for countdown_timer at CLK_HZ=1000; expected LED
// values come from preset arithmetic and elapsed-cycle counts, not the RTL.
module tb_countdown_timer;

    localparam int CLK_HZ      = 1000;
    localparam int DEBOUNCE_MS = 2;
    localparam int BLINK_DIV   = 4;
    localparam int HALF        = CLK_HZ / BLINK_DIV;
    // pmod edge to visible output: 2 sync flops, 2-cycle window, edge reg, FSM reg.
    localparam int PRESS_LAT   = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pmod;
    logic [3:0] led;
    logic       busy;
    logic       done;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int m_preset = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    countdown_timer #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .BLINK_DIV   (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pmod  (pmod),
        .led   (led),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_at(input logic [1:0] mask, input int eff);
        wait_until(eff - PRESS_LAT);
        pmod = pmod & ~mask;
        wait_until(eff);
    endtask

    task automatic press_now(input logic [1:0] mask, output int eff);
        @(posedge clk);
        #1;
        eff = cyc + PRESS_LAT;
        press_at(mask, eff);
    endtask

    task automatic release_btn(input logic [1:0] mask);
        repeat ($urandom_range(0, 4)) begin
            @(posedge clk);
            #1;
        end
        pmod = pmod | mask;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tap(input logic [1:0] mask);
        int e;
        press_now(mask, e);
        release_btn(mask);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pmod  = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_preset = 0;
    endtask

    task automatic set_preset(input int n);
        do_reset();
        repeat (n) tap(2'b01);
        m_preset = n % 16;
    endtask

    initial begin
        int e, t0, r, pp, n, p, rem;
        logic [1:0] gm;

        // Reset state
        rst_n = 1'b0;
        pmod  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led", led, 4'h0);
        chk("rst_busy", {3'b0, busy}, 4'h0);
        chk("rst_done", {3'b0, done}, 4'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: preset increments and wraps
        for (int i = 1; i <= 3; i++) begin
            press_now(2'b01, e);
            m_preset = (m_preset + 1) % 16;
            chk("t1_preset", led, 4'(m_preset));
            chk("t1_busy", {3'b0, busy}, 4'h0);
            release_btn(2'b01);
        end
        repeat (16) tap(2'b01);
        chk("t1_wrap", led, 4'h3);
        n = $urandom_range(1, 20);
        set_preset(n);
        chk("t1_rand", led, 4'(n % 16));

        // 2: full countdown from 2, done pulse, blink
        set_preset(2);
        press_now(2'b10, t0);
        chk("t2_busy", {3'b0, busy}, 4'h1);
        chk("t2_led0", led, 4'h2);
        release_btn(2'b10);
        wait_until(t0 + CLK_HZ - 1);
        chk("t2_pre_tick", led, 4'h2);
        wait_until(t0 + CLK_HZ);
        chk("t2_tick1", led, 4'h1);
        wait_until(t0 + 2 * CLK_HZ - 1);
        chk("t2_pre_zero", led, 4'h1);
        chk("t2_no_done", {3'b0, done}, 4'h0);
        wait_until(t0 + 2 * CLK_HZ);
        chk("t2_zero", led, 4'h0);
        chk("t2_done", {3'b0, done}, 4'h1);
        chk("t2_idle_busy", {3'b0, busy}, 4'h0);
        wait_until(t0 + 2 * CLK_HZ + 1);
        chk("t2_done_clr", {3'b0, done}, 4'h0);
        chk("t2_blink_on", led, 4'hF);
        wait_until(t0 + 2 * CLK_HZ + HALF);
        chk("t2_on_last", led, 4'hF);
        wait_until(t0 + 2 * CLK_HZ + HALF + 1);
        chk("t2_blink_off", led, 4'h0);
        wait_until(t0 + 2 * CLK_HZ + 2 * HALF);
        chk("t2_off_last", led, 4'h0);
        wait_until(t0 + 2 * CLK_HZ + 2 * HALF + 1);
        chk("t2_blink_on2", led, 4'hF);
        press_now(2'b01, e);
        chk("t2_exit", led, 4'(m_preset));
        chk("t2_exit_busy", {3'b0, busy}, 4'h0);
        release_btn(2'b01);

        // 3: pause at a random point, hold, resume keeps the partial second
        set_preset(5);
        press_now(2'b10, t0);
        release_btn(2'b10);
        pp = $urandom_range(50, 900);
        press_at(2'b10, t0 + pp);
        chk("t3_paused", led, 4'h5);
        release_btn(2'b10);
        wait_until(t0 + pp + 3000);
        chk("t3_hold", led, 4'h5);
        chk("t3_hold_busy", {3'b0, busy}, 4'h1);
        r = cyc + 20;
        press_at(2'b10, r);
        chk("t3_resume", led, 4'h5);
        release_btn(2'b10);
        rem = CLK_HZ - pp;
        wait_until(r + rem - 1);
        chk("t3_pre_tick", led, 4'h5);
        wait_until(r + rem);
        chk("t3_tick", led, 4'h4);

        // 4: start with preset 0 ignored; button 0 ignored in RUN
        do_reset();
        press_now(2'b10, e);
        chk("t4_zero_busy", {3'b0, busy}, 4'h0);
        chk("t4_zero_led", led, 4'h0);
        release_btn(2'b10);
        set_preset(3);
        press_now(2'b10, t0);
        release_btn(2'b10);
        press_at(2'b01, t0 + 300);
        chk("t4_b0_led", led, 4'h3);
        chk("t4_b0_busy", {3'b0, busy}, 4'h1);
        release_btn(2'b01);
        wait_until(t0 + CLK_HZ - 1);
        chk("t4_pre_tick", led, 4'h3);
        wait_until(t0 + CLK_HZ);
        chk("t4_tick", led, 4'h2);

        // 5: simultaneous presses and a pause landing on the tick
        p = $urandom_range(2, 15);
        set_preset(p);
        press_now(2'b11, t0);
        chk("t5_idle_both", led, 4'(p));
        chk("t5_run_busy", {3'b0, busy}, 4'h1);
        release_btn(2'b11);
        press_at(2'b11, t0 + 200);
        chk("t5_run_both", {3'b0, busy}, 4'h1);
        release_btn(2'b11);
        press_at(2'b11, cyc + 20);
        chk("t5_abort_led", led, 4'(p));
        chk("t5_abort_busy", {3'b0, busy}, 4'h0);
        release_btn(2'b11);
        press_now(2'b10, t0);
        chk("t5_restart", led, 4'(p));
        release_btn(2'b10);
        press_at(2'b10, t0 + CLK_HZ);
        chk("t5_tick_pause", led, 4'(p));
        release_btn(2'b10);
        wait_until(t0 + CLK_HZ + 500);
        chk("t5_held", led, 4'(p));
        r = cyc + 20;
        press_at(2'b10, r);
        chk("t5_resume", led, 4'(p));
        wait_until(r + 1);
        chk("t5_late_tick", led, 4'(p - 1));
        release_btn(2'b10);

        // 6: asynchronous reset mid-RUN, then glitches produce no press
        set_preset(3);
        press_now(2'b10, t0);
        release_btn(2'b10);
        wait_until(t0 + 400);
        chk("t6_running", led, 4'h3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_led", led, 4'h0);
        chk("t6_async_busy", {3'b0, busy}, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            gm = 2'($urandom_range(1, 3));
            @(posedge clk);
            #1;
            pmod = 2'b11 & ~gm;
            @(posedge clk);
            #1;
            pmod = 2'b11;
            repeat ($urandom_range(2, 5)) @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("t6_glitch_led", led, 4'h0);
        chk("t6_glitch_busy", {3'b0, busy}, 4'h0);
        press_now(2'b01, e);
        chk("t6_alive", led, 4'h1);
        release_btn(2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
